alu_cmd_issuer: RTL and testbench

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_issuer.sv | 141 ++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Purpose : accepts ALU commands, drives a registered external combinational ALU, captures its result as a response.
// Latency : response valid two edges after command accept; back-to-back issue from RESPOND without an idle bubble.
// Backpr. : rsp_ready=0 holds RESPOND with rsp_y/rsp_flags stable and cmd_ready low; cmd_ready is high only in IDLE or on response handoff.
// Ports   : clk/reset_n; cmd_* command channel (valid/ready, opcode, a, b, chain);
//           alu_* registered ALU drive and ALU result inputs; rsp_* response channel (valid/ready, y, flags);
//           err_count saturating count of invalid-opcode responses.
module alu_cmd_issuer #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_opcode,
  input  logic [BUS_WIDTH-1:0] cmd_a,
  input  logic [BUS_WIDTH-1:0] cmd_b,
  input  logic                 cmd_chain,
  output logic [3:0]           alu_opcode,
  output logic [BUS_WIDTH-1:0] alu_a,
  output logic [BUS_WIDTH-1:0] alu_b,
  output logic                 alu_carry_in,
  input  logic [BUS_WIDTH-1:0] alu_y,
  input  logic                 alu_carry_out,
  input  logic                 alu_borrow,
  input  logic                 alu_zero,
  input  logic                 alu_parity,
  input  logic                 alu_invalid_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_y,
  output logic [4:0]           rsp_flags,
  output logic [7:0]           err_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDC = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;

  state_t               state_q, state_d;
  logic [3:0]           opcode_q, opcode_d;
  logic [BUS_WIDTH-1:0] a_q, a_d;
  logic [BUS_WIDTH-1:0] b_q, b_d;
  logic                 cin_q, cin_d;
  logic [BUS_WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic [4:0]           flags_q, flags_d;
  logic [7:0]           err_q, err_d;
  logic                 carry_q, carry_d;
  logic [BUS_WIDTH-1:0] last_q, last_d;
  logic                 ready_c;
  logic                 accept_c;

  always_comb begin
    state_d  = state_q;
    ready_c  = 1'b0;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    rsp_y_d  = rsp_y_q;
    flags_d  = flags_q;
    err_d    = err_q;
    carry_d  = carry_q;
    last_d   = last_q;

    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (cmd_valid) state_d = ISSUE;
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        state_d  = RESPOND;
        rsp_y_d  = alu_y;
        last_d   = alu_y;
        flags_d  = {alu_invalid_op, alu_parity, alu_zero, alu_borrow, alu_carry_out};
        if (opcode_q == OP_ADD || opcode_q == OP_ADDC) carry_d = alu_carry_out;
        else if (opcode_q == OP_SUB)                   carry_d = alu_borrow;
        if (alu_invalid_op && err_q != 8'hFF) err_d = err_q + 8'd1;
        // ALU sees a NOP once the result is taken; operands are left as they were.
        opcode_d = 4'd0;
        cin_d    = 1'b0;
      end
      RESPOND: begin
        if (rsp_ready) begin
          ready_c = 1'b1;
          state_d = cmd_valid ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    accept_c = cmd_valid & ready_c;
    if (accept_c) begin
      opcode_d = cmd_opcode;
      a_d      = cmd_chain ? last_q : cmd_a;
      b_d      = cmd_b;
      // carry_q is already up to date here: any capture precedes the accept edge.
      cin_d    = (cmd_opcode == OP_ADDC) ? carry_q : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      rsp_y_q  <= '0;
      flags_q  <= '0;
      err_q    <= '0;
      carry_q  <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      rsp_y_q  <= rsp_y_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
      carry_q  <= carry_d;
      last_q   <= last_d;
    end
  end

  // Gated by reset so no command is offered acceptance while reset is held.
  assign cmd_ready    = reset_n & ready_c;
  assign rsp_valid    = (state_q == RESPOND);
  assign alu_opcode   = opcode_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_carry_in = cin_q;
  assign rsp_y        = rsp_y_q;
  assign rsp_flags    = flags_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: stub ALU, queue-based response model, directed scenarios.
module tb_alu_cmd_issuer;

  typedef struct packed {
    logic       inv;
    logic       par;
    logic       zero;
    logic       borrow;
    logic       cout;
    logic [7:0] y;
  } res_t;

  typedef struct {
    logic [7:0] y;
    logic [4:0] flags;
    logic [7:0] err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_ready, cmd_chain;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_carry_in, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_y;
  logic [4:0] rsp_flags;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t       exp_q[$];
  logic       m_carry = 1'b0;
  logic [7:0] m_last = 8'd0;
  logic [7:0] m_err = 8'd0;

  alu_cmd_issuer #(.BUS_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
    .alu_y(alu_y), .alu_carry_out(alu_carry_out), .alu_borrow(alu_borrow),
    .alu_zero(alu_zero), .alu_parity(alu_parity), .alu_invalid_op(alu_invalid_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_flags(rsp_flags), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Arithmetic definition of the ALU: used both as the stub and by the model.
  function automatic res_t alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin);
    res_t r;
    logic [8:0] s;
    r = '0;
    s = 9'd0;
    case (op)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; r.y = s[7:0]; r.cout = s[8]; end
      4'd2: begin s = {1'b0, a} + {1'b0, b} + {8'd0, cin}; r.y = s[7:0]; r.cout = s[8]; end
      4'd3: begin r.y = a - b; r.borrow = (a < b); end
      4'd4: r.y = a + 8'd1;
      4'd5: r.y = a - 8'd1;
      4'd6: r.y = a & b;
      4'd7: r.y = ~a;
      4'd8: r.y = {a[6:0], a[7]};
      4'd9: r.y = {a[0], a[7:1]};
      default: r.inv = 1'b1;
    endcase
    r.zero = (r.y == 8'd0);
    r.par  = ^r.y;
    return r;
  endfunction

  res_t alu_r;
  always_comb begin
    alu_r          = alu_f(alu_opcode, alu_a, alu_b, alu_carry_in);
    alu_y          = alu_r.y;
    alu_carry_out  = alu_r.cout;
    alu_borrow     = alu_r.borrow;
    alu_zero       = alu_r.zero;
    alu_parity     = alu_r.par;
    alu_invalid_op = alu_r.inv;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: one expected response per accepted command, dropped wholesale by reset.
  always @(posedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      m_carry = 1'b0;
      m_last  = 8'd0;
      m_err   = 8'd0;
    end else begin
      if (rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (cmd_valid && cmd_ready) begin
        logic [7:0] a;
        res_t r;
        exp_t e;
        a = cmd_chain ? m_last : cmd_a;
        r = alu_f(cmd_opcode, a, cmd_b, (cmd_opcode == 4'd2) ? m_carry : 1'b0);
        m_last = r.y;
        if (cmd_opcode == 4'd1 || cmd_opcode == 4'd2) m_carry = r.cout;
        else if (cmd_opcode == 4'd3)                 m_carry = r.borrow;
        if (r.inv && m_err != 8'hFF) m_err = m_err + 8'd1;
        e.y     = r.y;
        e.flags = {r.inv, r.par, r.zero, r.borrow, r.cout};
        e.err   = m_err;
        exp_q.push_back(e);
      end
    end
  end

  // Compare process: every cycle a response is presented.
  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      chk("mdl_rsp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        chk("mdl_rsp_y", {24'd0, rsp_y}, {24'd0, exp_q[0].y});
        chk("mdl_rsp_flags", {27'd0, rsp_flags}, {27'd0, exp_q[0].flags});
        chk("mdl_err_count", {24'd0, err_count}, {24'd0, exp_q[0].err});
      end
    end
  end

  task automatic do_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic chain, input logic [7:0] ey, input logic [4:0] ef,
                        input logic [7:0] ea, input logic ecin, input string nm);
    int waitc;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_chain = chain; rsp_ready = 1'b0;
    #1;
    waitc = 0;
    while (!cmd_ready && waitc < 20) begin
      @(negedge clk); #1;
      waitc++;
    end
    chk({nm, "_accept"}, {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({nm, "_issue_op"}, {28'd0, alu_opcode}, {28'd0, op});
    chk({nm, "_issue_a"}, {24'd0, alu_a}, {24'd0, ea});
    chk({nm, "_issue_cin"}, {31'd0, alu_carry_in}, {31'd0, ecin});
    chk({nm, "_issue_vld"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk({nm, "_capture_vld"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk({nm, "_rsp_vld"}, {31'd0, rsp_valid}, 32'd1);
    chk({nm, "_rsp_y"}, {24'd0, rsp_y}, {24'd0, ey});
    chk({nm, "_rsp_flags"}, {27'd0, rsp_flags}, {27'd0, ef});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_a = 8'd0; cmd_b = 8'd0;
    cmd_chain = 1'b0; rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_outputs", {alu_opcode, alu_a, alu_b, alu_carry_in, rsp_flags}, 32'd0);
    chk("rst_rsp_err", {16'd0, rsp_y, err_count}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Basic add
    do_cmd(4'd1, 8'd9, 8'd33, 1'b0, 8'd42, 5'b01000, 8'd9, 1'b0, "add");
    // Carry chain
    do_cmd(4'd1, 8'd200, 8'd100, 1'b0, 8'd44, 5'b01001, 8'd200, 1'b0, "add_co");
    do_cmd(4'd2, 8'd1, 8'd1, 1'b0, 8'd3, 5'b00000, 8'd1, 1'b1, "adc");
    // Result chain
    do_cmd(4'd3, 8'd65, 8'd66, 1'b0, 8'd255, 5'b00010, 8'd65, 1'b0, "sub");
    do_cmd(4'd4, 8'd7, 8'd0, 1'b1, 8'd0, 5'b00100, 8'd255, 1'b0, "inc_chain");
    // Invalid opcodes (carry_flag is 1 from the SUB borrow and must survive)
    do_cmd(4'd0, 8'd5, 8'd6, 1'b0, 8'd0, 5'b10100, 8'd5, 1'b0, "inv0");
    do_cmd(4'd12, 8'd5, 8'd6, 1'b0, 8'd0, 5'b10100, 8'd5, 1'b0, "inv12");
    chk("err_after_inv", {24'd0, err_count}, 32'd2);
    do_cmd(4'd2, 8'd0, 8'd0, 1'b0, 8'd1, 5'b01000, 8'd0, 1'b1, "adc_keep");

    // Backpressure then back-to-back handoff
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = 4'd1; cmd_a = 8'd3; cmd_b = 8'd4; cmd_chain = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_opcode = 4'd3; cmd_a = 8'd10; cmd_b = 8'd1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_y", {24'd0, rsp_y}, 32'd7);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("b2b_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    chk("b2b_issue_op", {28'd0, alu_opcode}, 32'd3);
    chk("b2b_issue_a", {24'd0, alu_a}, 32'd10);
    chk("b2b_issue_vld", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    chk("b2b_rsp_y", {24'd0, rsp_y}, 32'd9);
    chk("b2b_rsp_flags", {27'd0, rsp_flags}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_idle_vld", {31'd0, rsp_valid}, 32'd0);

    // Reset during CAPTURE
    cmd_valid = 1'b1; cmd_opcode = 4'd1; cmd_a = 8'd5; cmd_b = 8'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_alu", {alu_opcode, alu_a, alu_b, alu_carry_in, rsp_flags}, 32'd0);
    chk("mid_rst_rsp", {15'd0, rsp_valid, rsp_y, err_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("mid_rel_ready", {31'd0, cmd_ready}, 32'd1);
    do_cmd(4'd1, 8'd1, 8'd1, 1'b0, 8'd2, 5'b01000, 8'd1, 1'b0, "post_rst_add");
    chk("post_rst_err", {24'd0, err_count}, 32'd0);
    do_cmd(4'd2, 8'd1, 8'd1, 1'b0, 8'd2, 5'b01000, 8'd1, 1'b0, "post_rst_adc");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
